// File: rtl/prbs11_if.sv
// Bit-stream and status bundle between a PRBS11 source/sink and the checker.
interface prbs11_if #(
  parameter int unsigned CNT_W = 16
);
  logic             din_valid;
  logic             din;
  logic             clear_counts;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output din_valid, din, clear_counts,
    input  locked, err, err_count, bit_count
  );

  modport slave (
    input  din_valid, din, clear_counts,
    output locked, err, err_count, bit_count
  );
endinterface

// File: rtl/prbs11_checker.sv
// Self-synchronising PRBS11 (XNOR, taps 11/9) checker with lock tracking and
// saturating error/bit statistics.
module prbs11_checker #(
  parameter int unsigned LOCK_THRESH = 32,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 16
) (
  input logic     clk,
  input logic     reset,
  prbs11_if.slave bus
);
  localparam int unsigned HIST_W = 11;
  localparam int unsigned PERIOD = 2047;
  localparam int unsigned FILL_W = 4;
  localparam int unsigned CW     = 11;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state, state_n;
  logic [HIST_W-1:0]  hist, hist_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [CW-1:0]      match_cnt, match_n;
  logic [CW-1:0]      per_cnt, per_n;
  logic [CW-1:0]      win_err, win_n;
  logic [CNT_W-1:0]   err_count, err_count_n;
  logic [CNT_W-1:0]   bit_count, bit_count_n;
  logic               err_q, err_n;
  logic               locked_q;

  logic               pred;
  logic               miss;
  logic [HIST_W-1:0]  hist_din;
  logic [CW-1:0]      match_inc;
  logic               wrap;
  logic [CW-1:0]      win_base;
  logic [CW-1:0]      win_inc;

  assign pred      = ~(hist[10] ^ hist[8]);
  assign miss      = bus.din ^ pred;
  assign hist_din  = {hist[HIST_W-2:0], bus.din};
  assign match_inc = match_cnt + CW'(1);
  assign wrap      = (per_cnt == CW'(PERIOD - 1));
  // The wrap bit opens a new window, so it is counted against a cleared tally.
  assign win_base  = wrap ? '0 : win_err;
  assign win_inc   = win_base + CW'(1);

  // Next-state and statistics logic.
  always_comb begin
    state_n     = state;
    hist_n      = hist;
    fill_n      = fill;
    match_n     = match_cnt;
    per_n       = per_cnt;
    win_n       = win_err;
    err_count_n = err_count;
    bit_count_n = bit_count;
    err_n       = 1'b0;

    if (bus.din_valid) begin
      case (state)
        SEARCH: begin
          hist_n = hist_din;
          if (fill < FILL_W'(HIST_W)) begin
            fill_n = fill + FILL_W'(1);
          end else if (miss || (&hist_din)) begin
            match_n = '0;
          end else if (match_inc == CW'(LOCK_THRESH)) begin
            state_n = LOCKED;
            match_n = '0;
            per_n   = '0;
            win_n   = '0;
          end else begin
            match_n = match_inc;
          end
        end
        LOCKED: begin
          // Free-running reference: shift the prediction, not the received bit.
          hist_n = {hist[HIST_W-2:0], pred};
          per_n  = wrap ? '0 : per_cnt + CW'(1);
          win_n  = win_base;
          if (bit_count != {CNT_W{1'b1}}) bit_count_n = bit_count + CNT_W'(1);
          if (miss) begin
            err_n = 1'b1;
            win_n = win_inc;
            if (err_count != {CNT_W{1'b1}}) err_count_n = err_count + CNT_W'(1);
            if (win_inc == CW'(LOSS_THRESH)) begin
              state_n = SEARCH;
              fill_n  = '0;
              match_n = '0;
              per_n   = '0;
              win_n   = '0;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end

    if (bus.clear_counts) begin
      err_count_n = '0;
      bit_count_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      per_cnt   <= '0;
      win_err   <= '0;
      err_count <= '0;
      bit_count <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      per_cnt   <= per_n;
      win_err   <= win_n;
      err_count <= err_count_n;
      bit_count <= bit_count_n;
      err_q     <= err_n;
      locked_q  <= (state_n == LOCKED);
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count;
  assign bus.bit_count = bit_count;
endmodule

// File: doc/prbs11_checker.md
# prbs11_checker

Serial PRBS11 receiver/checker for the compressed-sensing measurement path. It consumes a bit stream produced by the team's PRBS11 generator, self-synchronises to it, then free-runs a local reference to count bit errors. It sits at the far end of any link or RAM readback carrying the PRBS11 chip sequence, and gives lock status and error statistics for link and memory bring-up.

## Interface
- `LOCK_THRESH`, 32: consecutive correct predictions required to declare lock; legal range 1..2047.
- `LOSS_THRESH`, 8: errors within one 2047-bit period that force loss of lock; legal range 1..2047.
- `CNT_W`, 16: width of the error and bit counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `din_valid` in 1: `din` is sampled only when this is high.
- `din` in 1: received PRBS bit.
- `clear_counts` in 1: synchronous clear of `err_count` and `bit_count`; lock state is unaffected.
- `locked` out 1: checker is in LOCKED.
- `err` out 1: one-cycle pulse when a checked bit mismatches while LOCKED.
- `err_count` out CNT_W: saturating count of mismatches while LOCKED.
- `bit_count` out CNT_W: saturating count of bits checked while LOCKED.

## Operation
- **Sequence definition.** Bit stream b[n] obeys b[n] = ~(b[n-11] ^ b[n-9]), the XNOR form. A zero seed gives 11 zeros followed by a 1.
- **History register.** 11-bit `hist`, with `hist[0]` the newest bit. Prediction is `pred = ~(hist[10] ^ hist[8])`.
- **All-ones lockup.** All-ones is the lockup state: it satisfies the recurrence but is not a valid sequence.
- **States.** SEARCH and LOCKED. Reset enters SEARCH with `hist=0`, `fill=0`, `match_cnt=0`, `per_cnt=0`, `win_err=0`.
- **SEARCH, each valid bit:**
  - While `fill<11`: shift `din` into `hist`, `fill++`, no compare.
  - Once `fill==11`: compare `din` against `pred`. Match gives `match_cnt++`; mismatch gives `match_cnt=0`. Always shift `din` into `hist`, so the checker self-synchronises.
  - Go to LOCKED when the incremented `match_cnt` equals `LOCK_THRESH` and the updated `hist` is not all ones.
  - If `hist` is all ones, hold `match_cnt=0`. An all-ones stream never locks.
- **LOCKED, each valid bit:**
  - Compare `din` against `pred` and shift `pred` (not `din`) into `hist`. The local reference free-runs, so one bit error yields exactly one error.
  - `bit_count++` on every checked bit.
  - On mismatch: `err_count++`, `win_err++`, and `err` pulses.
  - `per_cnt` counts 0..2046 and wraps to 0. At the wrap, `win_err` is cleared; an error on the wrap bit then sets `win_err` to 1.
  - When `win_err` reaches `LOSS_THRESH`, go to SEARCH and clear `fill`, `match_cnt`, `per_cnt` and `win_err`.
- **Counter rules.** Both counters saturate at 2^CNT_W-1 and never wrap. `clear_counts` has priority over an increment in the same cycle, so the result is 0.
- **Invalid cycles.** When `din_valid` is low, no state changes except from `clear_counts`, and `err` is low.

## Timing
- **Reset values.** `locked=0`, `err=0`, `err_count=0`, `bit_count=0`; all take effect immediately on reset assertion.
- **Registered outputs.** Every output is registered. The effect of the bit sampled at edge k is visible after edge k.
- **Lock latency.** From reset with a clean stream and no gaps, `locked` rises after valid bit number 11+`LOCK_THRESH`, which is bit 43 at the default.
- **Error flag.** `err` is high for exactly the cycle after the erroneous bit is sampled. `err_count` updates on the same edge.
- **Loss latency.** `locked` falls on the edge that samples the `LOSS_THRESH`-th error in the window. That bit is still counted in `err_count`.
- **Gaps.** Gaps in `din_valid` of any length neither break lock nor advance `per_cnt`.
- **Reset mid-operation.** Asynchronous abort to the reset values; a new search starts from `fill=0`.

## Test plan
- **Clean lock.** Zero-seed PRBS11 stream, `din_valid` always high, defaults -> `locked` rises after bit 43; over 3×2047 further bits, `err=0`, `err_count=0` and `bit_count` equals the bits checked.
- **Single error.** Once locked, invert 1 bit -> exactly one `err` pulse, `err_count=1`, `locked` stays 1 (no error multiplication).
- **Loss of lock.** Invert 8 bits within 500 bits -> `locked` falls on the edge of the 8th error, `err_count=8`. With a clean stream resumed, relock occurs 43 valid bits later.
- **Window wrap.** 7 errors per 2047-bit period for 4 periods -> `locked` never falls, `err_count=28`.
- **Lockup and noise.** Constant-1 stream for 5000 bits -> `locked` never asserts. Random data -> no lock in 10^5 bits with `LOCK_THRESH=32`.
- **Gaps, saturation, clear, reset.**
  - Random `din_valid` gaps -> same results as the gapless run.
  - `CNT_W=4` with 20 errors -> `err_count` holds 15.
  - `clear_counts` together with an error -> 0.
  - Assert `reset` mid-lock -> all outputs 0 immediately.
